// File: rtl/elevator_pkg.sv
// Shared types, codes and floor helpers for the 3-floor elevator controller.
package elevator_pkg;

  localparam int NUM_FLOORS = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_DOOR_OPEN = 3'd3,
    ST_ESTOP     = 3'd4
  } state_t;

  localparam logic [1:0] ENG_STOP   = 2'b00;
  localparam logic [1:0] ENG_UP     = 2'b01;
  localparam logic [1:0] ENG_DOWN   = 2'b10;
  localparam logic [3:0] MGMT_ESTOP = 4'b1101;
  localparam logic [3:0] MGMT_HOME  = 4'b1011;

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [1:0] f);
    case (f)
      2'd0:    floor_onehot = 3'b001;
      2'd1:    floor_onehot = 3'b010;
      2'd2:    floor_onehot = 3'b100;
      default: floor_onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [NUM_FLOORS-1:0] calls_above(input logic [NUM_FLOORS-1:0] req,
                                                        input logic [1:0] f);
    case (f)
      2'd0:    calls_above = req & 3'b110;
      2'd1:    calls_above = req & 3'b100;
      default: calls_above = 3'b000;
    endcase
  endfunction

  function automatic logic [NUM_FLOORS-1:0] calls_below(input logic [NUM_FLOORS-1:0] req,
                                                        input logic [1:0] f);
    case (f)
      2'd1:    calls_below = req & 3'b001;
      2'd2:    calls_below = req & 3'b011;
      default: calls_below = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module elevator_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count_r;

  // Clear beats load, load beats decrement; the counter parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == '0);

endmodule

// File: rtl/elevator.sv
// Top-level elevator FSM: call latching, management decode, travel/door sequencing, output decode.
module elevator
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] BCD_management,
  input  logic [2:0] interior_movement,
  input  logic [2:0] exterior_movement,
  output logic [1:0] engine,
  output logic [2:0] doors
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  state_t     state_r, state_n_s;
  logic [1:0] floor_r, floor_n_s, nf_s;
  logic       dir_r, dir_n_s;
  logic [2:0] pend_r, pend_n_s, calls_s, req_s;
  logic       estop_s, home_s, run_en_s;
  logic       tr_load_s, tr_en_s, tr_done_s;
  logic       dr_load_s, dr_en_s, dr_done_s;
  logic       tmr_clr_s, arrive_s, up_s;

  elevator_timer #(.WIDTH(TW)) u_travel (
    .clk(CLK), .rst(RST), .clr(tmr_clr_s), .load(tr_load_s),
    .load_val(TRAVEL_LOAD), .en(tr_en_s), .done(tr_done_s)
  );

  elevator_timer #(.WIDTH(TW)) u_door (
    .clk(CLK), .rst(RST), .clr(tmr_clr_s), .load(dr_load_s),
    .load_val(DOOR_LOAD), .en(dr_en_s), .done(dr_done_s)
  );

  // Next-state, request and timer-control logic.
  always_comb begin
    estop_s   = (BCD_management == MGMT_ESTOP);
    home_s    = (BCD_management == MGMT_HOME);
    run_en_s  = BCD_management[0] & ~estop_s;
    calls_s   = interior_movement | exterior_movement;
    if (state_r == ST_DOOR_OPEN) begin
      calls_s = calls_s & ~floor_onehot(floor_r);
    end else begin
      calls_s = calls_s;
    end
    req_s     = home_s ? 3'b001 : (pend_r | calls_s);
    state_n_s = state_r;
    floor_n_s = floor_r;
    dir_n_s   = dir_r;
    pend_n_s  = req_s;
    nf_s      = floor_r;
    tr_load_s = 1'b0;
    tr_en_s   = 1'b0;
    dr_load_s = 1'b0;
    dr_en_s   = 1'b0;
    tmr_clr_s = 1'b0;
    arrive_s  = 1'b0;
    up_s      = 1'b0;

    if (estop_s) begin
      state_n_s = ST_ESTOP;
      pend_n_s  = 3'b000;
      tmr_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!run_en_s) begin
            state_n_s = ST_IDLE;
          end else if ((req_s & floor_onehot(floor_r)) != 3'b000) begin
            state_n_s = ST_DOOR_OPEN;
            pend_n_s  = req_s & ~floor_onehot(floor_r);
            dr_load_s = 1'b1;
          end else if ((calls_above(req_s, floor_r) != 3'b000) &&
                       (dir_r || (calls_below(req_s, floor_r) == 3'b000))) begin
            state_n_s = ST_MOVE_UP;
            dir_n_s   = 1'b1;
            tr_load_s = 1'b1;
          end else if (calls_below(req_s, floor_r) != 3'b000) begin
            state_n_s = ST_MOVE_DOWN;
            dir_n_s   = 1'b0;
            tr_load_s = 1'b1;
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_MOVE_UP: begin
          if (tr_done_s) begin
            arrive_s = 1'b1;
            up_s     = 1'b1;
          end else begin
            tr_en_s = 1'b1;
          end
        end
        ST_MOVE_DOWN: begin
          if (tr_done_s) begin
            arrive_s = 1'b1;
            up_s     = 1'b0;
          end else begin
            tr_en_s = 1'b1;
          end
        end
        ST_DOOR_OPEN: begin
          if (dr_done_s) begin
            state_n_s = ST_IDLE;
          end else begin
            dr_en_s = 1'b1;
          end
        end
        ST_ESTOP: begin
          state_n_s = ST_IDLE;
          pend_n_s  = 3'b000;
          tmr_clr_s = 1'b1;
        end
        default: begin
          state_n_s = ST_IDLE;
          pend_n_s  = 3'b000;
          tmr_clr_s = 1'b1;
        end
      endcase
    end

    // Arrival: step the floor (clamped at the shafts ends), then stop, continue or idle.
    if (arrive_s) begin
      if (up_s) begin
        nf_s = (floor_r == 2'd2) ? floor_r : floor_r + 2'd1;
      end else begin
        nf_s = (floor_r == 2'd0) ? floor_r : floor_r - 2'd1;
      end
      floor_n_s = nf_s;
      if ((req_s & floor_onehot(nf_s)) != 3'b000) begin
        state_n_s = ST_DOOR_OPEN;
        pend_n_s  = req_s & ~floor_onehot(nf_s);
        dr_load_s = 1'b1;
      end else if (run_en_s && ((up_s ? calls_above(req_s, nf_s)
                                      : calls_below(req_s, nf_s)) != 3'b000)) begin
        state_n_s = state_r;
        tr_load_s = 1'b1;
      end else begin
        state_n_s = ST_IDLE;
      end
    end else begin
      nf_s = floor_r;
    end
  end

  // State registers with outputs decoded from the next state so they line up with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      floor_r <= 2'd0;
      dir_r   <= 1'b1;
      pend_r  <= 3'b000;
      engine  <= ENG_STOP;
      doors   <= 3'b000;
    end else begin
      state_r <= state_n_s;
      floor_r <= floor_n_s;
      dir_r   <= dir_n_s;
      pend_r  <= pend_n_s;
      engine  <= (state_n_s == ST_MOVE_UP)   ? ENG_UP :
                 (state_n_s == ST_MOVE_DOWN) ? ENG_DOWN : ENG_STOP;
      doors   <= (state_n_s == ST_DOOR_OPEN) ? floor_onehot(floor_n_s) : 3'b000;
    end
  end

endmodule

// File: tb/tb_elevator.sv
// Directed bench for the elevator controller with hand-computed engine/door sequences.
module tb_elevator;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] BCD_management = 4'b0001;
  logic [2:0] interior_movement = 3'b000;
  logic [2:0] exterior_movement = 3'b000;
  logic [1:0] engine;
  logic [2:0] doors;

  int total = 0;
  int bad   = 0;

  elevator #(.TRAVEL_CYCLES(2), .DOOR_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .BCD_management(BCD_management),
    .interior_movement(interior_movement), .exterior_movement(exterior_movement),
    .engine(engine), .doors(doors)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Check outputs for n consecutive cycles, advancing one clock after each check.
  task automatic expect_cycles(input string tag, input int n,
                               input logic [1:0] eng, input logic [2:0] dr);
    for (int i = 0; i < n; i++) begin
      check({tag, "_eng"}, {2'b00, engine}, {2'b00, eng});
      check({tag, "_door"}, {1'b0, doors}, {1'b0, dr});
      step();
    end
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check("rst_eng", {2'b00, engine}, 4'b0000);
    check("rst_door", {1'b0, doors}, 4'b0000);
    RST = 1'b0;
    expect_cycles("idle", 3, 2'b00, 3'b000);

    interior_movement = 3'b001;
    step();
    interior_movement = 3'b000;
    expect_cycles("door0", 2, 2'b00, 3'b001);
    expect_cycles("door0_close", 1, 2'b00, 3'b000);

    exterior_movement = 3'b100;
    step();
    exterior_movement = 3'b000;
    expect_cycles("up2", 4, 2'b01, 3'b000);
    expect_cycles("door2", 2, 2'b00, 3'b100);
    expect_cycles("idle2", 1, 2'b00, 3'b000);

    BCD_management = 4'b1011;
    step();
    BCD_management = 4'b0001;
    expect_cycles("home_down", 4, 2'b10, 3'b000);
    expect_cycles("home_door", 2, 2'b00, 3'b001);
    expect_cycles("home_idle", 1, 2'b00, 3'b000);

    exterior_movement = 3'b100;
    step();
    exterior_movement = 3'b000;
    expect_cycles("pre_estop", 1, 2'b01, 3'b000);
    BCD_management = 4'b1101;
    step();
    expect_cycles("estop", 1, 2'b00, 3'b000);
    BCD_management = 4'b0001;
    expect_cycles("estop_exit", 4, 2'b00, 3'b000);

    BCD_management = 4'b0000;
    interior_movement = 3'b010;
    step();
    interior_movement = 3'b000;
    expect_cycles("no_run", 3, 2'b00, 3'b000);
    BCD_management = 4'b0001;
    step();
    expect_cycles("run_up1", 2, 2'b01, 3'b000);
    expect_cycles("door1", 2, 2'b00, 3'b010);
    expect_cycles("door1_close", 1, 2'b00, 3'b000);

    interior_movement = 3'b010;
    step();
    expect_cycles("held_door", 2, 2'b00, 3'b010);
    expect_cycles("held_gap", 1, 2'b00, 3'b000);
    expect_cycles("held_reopen", 1, 2'b00, 3'b010);
    interior_movement = 3'b000;
    step();
    expect_cycles("held_done", 1, 2'b00, 3'b000);

    exterior_movement = 3'b001;
    step();
    exterior_movement = 3'b000;
    check("mid_down_eng", {2'b00, engine}, 4'b0010);
    RST = 1'b1;
    #1;
    check("async_rst_eng", {2'b00, engine}, 4'b0000);
    check("async_rst_door", {1'b0, doors}, 4'b0000);
    step();
    RST = 1'b0;
    expect_cycles("post_rst", 2, 2'b00, 3'b000);
    interior_movement = 3'b001;
    step();
    interior_movement = 3'b000;
    expect_cycles("rst_floor0", 2, 2'b00, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
